// File: rtl/product_block_accumulator.sv
// Collects BLOCK_LEN unsigned products per block and presents one registered
// result per block (wrapped sum, sticky overflow, min, max) on a valid/ready port.
module product_block_accumulator #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int BLOCK_LEN = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [7:0]        fill_cnt
);

  localparam logic [7:0] LAST = 8'(BLOCK_LEN - 1);

  logic [ACC_W-1:0]  acc;
  logic              ovf;
  logic [DATA_W-1:0] run_min;
  logic [DATA_W-1:0] run_max;

  logic              in_fire;
  logic              out_fire;
  logic              is_final;
  logic [ACC_W:0]    sum_ext;
  logic              next_ovf;
  logic [DATA_W-1:0] next_min;
  logic [DATA_W-1:0] next_max;

  // A held result only blocks the input when the sink is not taking it now.
  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign is_final = (fill_cnt == LAST);

  // The extra top bit of sum_ext is the carry out of the ACC_W-bit accumulator.
  assign sum_ext  = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
  assign next_ovf = ovf | sum_ext[ACC_W];
  assign next_min = (in_data < run_min) ? in_data : run_min;
  assign next_max = (in_data > run_max) ? in_data : run_max;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc       <= '0;
      ovf       <= 1'b0;
      run_min   <= '1;
      run_max   <= '0;
      fill_cnt  <= 8'd0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_min   <= '0;
      out_max   <= '0;
    end else begin
      if (in_fire && is_final) begin
        out_sum   <= sum_ext[ACC_W-1:0];
        out_ovf   <= next_ovf;
        out_min   <= next_min;
        out_max   <= next_max;
        out_valid <= 1'b1;
        acc       <= '0;
        ovf       <= 1'b0;
        run_min   <= '1;
        run_max   <= '0;
        fill_cnt  <= 8'd0;
      end else begin
        if (in_fire) begin
          acc      <= sum_ext[ACC_W-1:0];
          ovf      <= next_ovf;
          run_min  <= next_min;
          run_max  <= next_max;
          fill_cnt <= fill_cnt + 8'd1;
        end
        // Result data stays put after the sink takes it; only valid drops.
        if (out_fire) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_product_block_accumulator.sv
// Bench for product_block_accumulator: directed table, corner sequences on three
// parameterisations, and randomized traffic against a queue-based reference model.
module tb_product_block_accumulator;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_N;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [7:0]  a_in_data, a_out_min, a_out_max, a_fill_cnt;
  logic [15:0] a_out_sum;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [7:0]  b_in_data, b_out_min, b_out_max, b_fill_cnt;
  logic [8:0]  b_out_sum;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
  logic [7:0]  c_in_data, c_out_min, c_out_max, c_fill_cnt;
  logic [15:0] c_out_sum;

  product_block_accumulator #(.DATA_W(8), .ACC_W(16), .BLOCK_LEN(4)) dutA (
    .CLK(CLK), .RST_N(RST_N), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf), .out_min(a_out_min),
    .out_max(a_out_max), .fill_cnt(a_fill_cnt));

  product_block_accumulator #(.DATA_W(8), .ACC_W(9), .BLOCK_LEN(4)) dutB (
    .CLK(CLK), .RST_N(RST_N), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf), .out_min(b_out_min),
    .out_max(b_out_max), .fill_cnt(b_fill_cnt));

  product_block_accumulator #(.DATA_W(8), .ACC_W(16), .BLOCK_LEN(1)) dutC (
    .CLK(CLK), .RST_N(RST_N), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_ready(c_in_ready), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum), .out_ovf(c_out_ovf), .out_min(c_out_min),
    .out_max(c_out_max), .fill_cnt(c_fill_cnt));

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        r;
    logic        ir;
    logic        ov;
    logic [15:0] sum;
    logic        ovf;
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [7:0]  fill;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] t2Data[4] = '{8'h19, 8'h26, 8'h00, 8'hFF};

  // Reference model for dutA: a queue holds the partial block; a result is
  // computed from the whole block with plain integer arithmetic.
  int unsigned mq[$];
  logic        mValid = 1'b0;
  int unsigned mSum = 0;
  logic        mOvf = 1'b0;
  int unsigned mMin = 0;
  int unsigned mMax = 0;

  always @(posedge CLK) begin
    bit accept, take;
    int unsigned tot, mn, mx;
    if (!RST_N) begin
      mq.delete();
      mValid = 1'b0; mSum = 0; mOvf = 1'b0; mMin = 0; mMax = 0;
    end else begin
      accept = a_in_valid && (!mValid || a_out_ready);
      take   = mValid && a_out_ready;
      if (accept) mq.push_back(int'(a_in_data));
      if (mq.size() == 4) begin
        tot = 0; mn = 255; mx = 0;
        foreach (mq[i]) begin
          tot += mq[i];
          if (mq[i] < mn) mn = mq[i];
          if (mq[i] > mx) mx = mq[i];
        end
        mSum = tot % 65536; mOvf = (tot > 65535); mMin = mn; mMax = mx;
        mValid = 1'b1;
        mq.delete();
      end else if (take) begin
        mValid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    a_in_valid  = v;
    a_in_data   = d;
    a_out_ready = r;
    #1;
  endtask

  task automatic checkA(input string tag, input logic ov, input logic [15:0] sum, input logic ovf,
                        input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] fill);
    checkOutput({tag, ".out_valid"}, 32'(a_out_valid), 32'(ov));
    checkOutput({tag, ".out_sum"},   32'(a_out_sum),   32'(sum));
    checkOutput({tag, ".out_ovf"},   32'(a_out_ovf),   32'(ovf));
    checkOutput({tag, ".out_min"},   32'(a_out_min),   32'(mn));
    checkOutput({tag, ".out_max"},   32'(a_out_max),   32'(mx));
    checkOutput({tag, ".fill_cnt"},  32'(a_fill_cnt),  32'(fill));
  endtask

  task automatic checkModel();
    checkOutput("rand.out_valid", 32'(a_out_valid), 32'(mValid));
    checkOutput("rand.fill_cnt",  32'(a_fill_cnt),  32'(mq.size()));
    if (mValid) begin
      checkOutput("rand.out_sum", 32'(a_out_sum), mSum);
      checkOutput("rand.out_ovf", 32'(a_out_ovf), 32'(mOvf));
      checkOutput("rand.out_min", 32'(a_out_min), mMin);
      checkOutput("rand.out_max", 32'(a_out_max), mMax);
    end
  endtask

  initial begin
    // Table: v, d, r, in_ready(pre-edge), then post-edge out_valid, sum, ovf, min, max, fill.
    tbl.push_back('{1'b1, 8'hB6, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 8'd1});
    tbl.push_back('{1'b1, 8'hB6, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 8'd2});
    tbl.push_back('{1'b1, 8'hB6, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 8'd3});
    tbl.push_back('{1'b1, 8'hB6, 1'b1, 1'b1, 1'b1, 16'h02D8, 1'b0, 8'hB6, 8'hB6, 8'd0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h02D8, 1'b0, 8'hB6, 8'hB6, 8'd0});
    tbl.push_back('{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 16'h02D8, 1'b0, 8'hB6, 8'hB6, 8'd1});
    tbl.push_back('{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 16'h02D8, 1'b0, 8'hB6, 8'hB6, 8'd2});
    tbl.push_back('{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 16'h02D8, 1'b0, 8'hB6, 8'hB6, 8'd3});
    tbl.push_back('{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 16'h000A, 1'b0, 8'h01, 8'h04, 8'd0});
    tbl.push_back('{1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 16'h000A, 1'b0, 8'h01, 8'h04, 8'd1});
    tbl.push_back('{1'b1, 8'h06, 1'b1, 1'b1, 1'b0, 16'h000A, 1'b0, 8'h01, 8'h04, 8'd2});
    tbl.push_back('{1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 16'h000A, 1'b0, 8'h01, 8'h04, 8'd3});
    tbl.push_back('{1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 16'h001A, 1'b0, 8'h05, 8'h08, 8'd0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h001A, 1'b0, 8'h05, 8'h08, 8'd0});

    RST_N = 1'b0;
    a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = 8'h00; c_out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    checkA("reset", 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 8'd0);
    checkOutput("reset.in_ready", 32'(a_in_ready), 32'd1);
    RST_N = 1'b1;

    // Back-to-back blocks with an always-ready sink.
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].v, tbl[i].d, tbl[i].r);
      checkOutput($sformatf("tbl%0d.in_ready", i), 32'(a_in_ready), 32'(tbl[i].ir));
      @(negedge CLK);
      checkA($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].sum, tbl[i].ovf, tbl[i].mn, tbl[i].mx, tbl[i].fill);
    end

    // Stalled sink: result and partial accumulation freeze, next input waits upstream.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, t2Data[i], 1'b0);
      checkOutput("stall.fill_in_ready", 32'(a_in_ready), 32'd1);
      @(negedge CLK);
    end
    checkA("stall.result", 1'b1, 16'h013E, 1'b0, 8'h00, 8'hFF, 8'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h33, 1'b0);
      checkOutput("stall.in_ready", 32'(a_in_ready), 32'd0);
      @(negedge CLK);
      checkA("stall.hold", 1'b1, 16'h013E, 1'b0, 8'h00, 8'hFF, 8'd0);
    end
    applyStimulus(1'b1, 8'h33, 1'b1);
    checkOutput("release.in_ready", 32'(a_in_ready), 32'd1);
    @(negedge CLK);
    checkA("release", 1'b0, 16'h013E, 1'b0, 8'h00, 8'hFF, 8'd1);
    applyStimulus(1'b1, 8'h44, 1'b0);
    @(negedge CLK);
    checkOutput("partial.fill_cnt", 32'(a_fill_cnt), 32'd2);

    // Reset in the middle of a partial block leaves no residue.
    applyStimulus(1'b0, 8'h00, 1'b0);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    checkA("midreset", 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 8'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h10, 1'b1);
      @(negedge CLK);
    end
    checkA("postreset", 1'b1, 16'h0040, 1'b0, 8'h10, 8'h10, 8'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge CLK);

    // Narrow accumulator wraps and flags overflow, then the flag clears.
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = 8'hFF;
    repeat (4) @(negedge CLK);
    checkOutput("wrap.out_valid", 32'(b_out_valid), 32'd1);
    checkOutput("wrap.out_sum",   32'(b_out_sum),   32'h1FC);
    checkOutput("wrap.out_ovf",   32'(b_out_ovf),   32'd1);
    checkOutput("wrap.out_max",   32'(b_out_max),   32'hFF);
    b_in_data = 8'h01;
    repeat (4) @(negedge CLK);
    checkOutput("nowrap.out_valid", 32'(b_out_valid), 32'd1);
    checkOutput("nowrap.out_sum",   32'(b_out_sum),   32'h004);
    checkOutput("nowrap.out_ovf",   32'(b_out_ovf),   32'd0);
    checkOutput("nowrap.out_min",   32'(b_out_min),   32'h01);
    b_in_valid = 1'b0;

    // Single-product blocks: every handshake is final, results back-to-back.
    c_out_ready = 1'b1;
    c_in_valid  = 1'b1;
    c_in_data   = 8'h05;
    @(negedge CLK);
    checkOutput("blk1a.out_valid", 32'(c_out_valid), 32'd1);
    checkOutput("blk1a.out_sum",   32'(c_out_sum),   32'h0005);
    checkOutput("blk1a.out_min",   32'(c_out_min),   32'h05);
    checkOutput("blk1a.out_max",   32'(c_out_max),   32'h05);
    checkOutput("blk1a.fill_cnt",  32'(c_fill_cnt),  32'd0);
    c_in_data = 8'h07;
    #1;
    checkOutput("blk1b.in_ready", 32'(c_in_ready), 32'd1);
    @(negedge CLK);
    checkOutput("blk1b.out_valid", 32'(c_out_valid), 32'd1);
    checkOutput("blk1b.out_sum",   32'(c_out_sum),   32'h0007);
    checkOutput("blk1b.out_min",   32'(c_out_min),   32'h07);
    checkOutput("blk1b.out_max",   32'(c_out_max),   32'h07);
    checkOutput("blk1b.fill_cnt",  32'(c_fill_cnt),  32'd0);
    c_in_valid = 1'b0;
    @(negedge CLK);
    checkOutput("blk1c.out_valid", 32'(c_out_valid), 32'd0);
    checkOutput("blk1c.out_sum",   32'(c_out_sum),   32'h0007);

    // Randomized traffic with occasional resets, checked against the model.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] d;
      case ($urandom_range(0, 3))
        0: d = 8'hFF;
        1: d = 8'h00;
        default: d = 8'($urandom);
      endcase
      RST_N = ($urandom_range(0, 59) != 0);
      applyStimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
      checkOutput("rand.in_ready", 32'(a_in_ready), 32'(!mValid || a_out_ready));
      @(negedge CLK);
      checkModel();
    end
    RST_N = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
